// File: rtl/credit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : credit_pkg
//  Description : Shared types and helpers for the credit-based link transmitter.
//  Revision    : 1.0  initial release
// ============================================================================
package credit_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ACTIVE   = 2'd1,
        DRAIN    = 2'd2
    } credit_tx_state_e;

    // Width needed to hold every value from 0 up to and including max.
    function automatic int crd_cnt_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/credit_tx_skid.sv
`default_nettype none
// ============================================================================
//  Module      : credit_tx_skid
//  Description : Two-entry FIFO between the upstream handshake and the link.
//                not_full is registered so the upstream ready path starts
//                at a flop.
//  Revision    : 1.0  initial release
// ============================================================================
module credit_tx_skid #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            entries,
    output logic                  not_full
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            entries_nxt;

    // Occupancy after this cycle's push/pop; a push never arrives when full.
    always_comb begin
        entries_nxt = entries;
        case ({push, pop})
            2'b10:   entries_nxt = entries + 2'd1;
            2'b01:   entries_nxt = entries - 2'd1;
            default: entries_nxt = entries;
        endcase
    end

    // Pointers, occupancy and registered not_full; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            entries  <= 2'd0;
            not_full <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            entries  <= entries_nxt;
            not_full <= (entries_nxt != 2'd2);
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/credit_tx.sv
`default_nettype none
// ============================================================================
//  Module      : credit_tx
//  Description : Transmit end of a credit-based link. Accepts flits through a
//                2-entry skid buffer and sends one flit per held credit on a
//                link without backpressure. Provides a drain sequence that
//                ends with a flush_done pulse once all credits are home.
//  Options     : CREDIT_TX_ERR_EN - when defined, crd_err latches a credit
//                overflow until reset; otherwise crd_err is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module credit_tx
    import credit_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_CREDITS = 8,
    parameter int CNT_W       = crd_cnt_w(MAX_CREDITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  flush_req,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  crd_rtn,
    output logic [CNT_W-1:0]      credit_avail,
    output logic                  flush_done,
    output logic                  crd_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CREDITS);

    credit_tx_state_e      state;
    credit_tx_state_e      state_nxt;
    logic [1:0]            entries;
    logic                  skid_not_full;
    logic [DATA_WIDTH-1:0] head;
    logic                  push;
    logic                  pop;
    logic                  drain_done;

    credit_tx_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (head),
        .entries   (entries),
        .not_full  (skid_not_full)
    );

    // Ready depends only on flops so the upstream sees no combinational path.
    assign in_ready   = (state == ACTIVE) && skid_not_full;
    assign push       = in_valid && in_ready;
    // Sending uses the registered count, so a pop can never reach zero-minus-one.
    assign pop        = (entries != 2'd0) && (credit_avail != '0) && (state != DISABLED);
    // Drain is complete once nothing is buffered, in flight, or owed back.
    assign drain_done = (entries == 2'd0) && !tx_valid && (credit_avail == MAX_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= DISABLED;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for enable, drain request and drain completion.
    always_comb begin
        state_nxt = state;
        case (state)
            DISABLED: if (enable) state_nxt = ACTIVE;
            ACTIVE:   if (flush_req || !enable) state_nxt = DRAIN;
            DRAIN:    if (drain_done) state_nxt = enable ? ACTIVE : DISABLED;
            default:  state_nxt = DISABLED;
        endcase
    end

    // Flush completion pulse, raised for the single cycle after leaving DRAIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_done <= 1'b0;
        end else begin
            flush_done <= (state == DRAIN) && drain_done;
        end
    end

    // Link output register; data holds its last value when no flit is sent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_valid <= pop;
            if (pop) begin
                tx_data <= head;
            end
        end
    end

    // Credit counter: pop spends one, return adds one, saturating at the maximum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_avail <= MAX_CNT;
        end else begin
            case ({pop, crd_rtn})
                2'b10: credit_avail <= credit_avail - CNT_W'(1);
                2'b01: begin
                    if (credit_avail != MAX_CNT) begin
                        credit_avail <= credit_avail + CNT_W'(1);
                    end
                end
                default: credit_avail <= credit_avail;
            endcase
        end
    end

`ifdef CREDIT_TX_ERR_EN
    logic crd_err_q;
    logic overflow;

    assign overflow = crd_rtn && !pop && (credit_avail == MAX_CNT);

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crd_err_q <= 1'b0;
        end else if (overflow) begin
            crd_err_q <= 1'b1;
        end
    end

    assign crd_err = crd_err_q;
`else
    assign crd_err = 1'b0;
`endif

endmodule
`default_nettype wire
